// File: rtl/frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ctrl
//  Description : Stack frame controller. Decodes PUSH / POP / CALL / RET /
//                DROPN commands into registered stack operations, tracks the
//                stack index and the current underflow limit, and keeps a
//                LIFO of saved limits for nested call frames. A DROPN of N
//                entries is spread over N consecutive pop cycles.
//  Options     : FRAME_CTRL_ARITY_CHECK_EN - when defined, RET checks that
//                the number of entries above the limit equals cmd_count and
//                flags an arity error (err=3) otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_ctrl #(
    parameter int WIDTH  = 8,   // stack data width
    parameter int DEPTH  = 8,   // stack index is DEPTH+1 bits, capacity 2^DEPTH
    parameter int FRAMES = 4    // frame LIFO holds 2^FRAMES saved limits
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [DEPTH:0]    cmd_count,
    output logic [1:0]        stk_op,
    output logic [WIDTH-1:0]  stk_data,
    output logic [DEPTH:0]    stk_limit,
    output logic [DEPTH:0]    depth,
    output logic [FRAMES:0]   level,
    output logic              busy,
    output logic [1:0]        err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int NFRAMES = 1 << FRAMES;

    // Full-stack index and full-LIFO level, both one past the last slot
    localparam logic [DEPTH:0]  MAXD     = {1'b1, {DEPTH{1'b0}}};
    localparam logic [FRAMES:0] MAXF     = {1'b1, {FRAMES{1'b0}}};
    localparam logic [DEPTH:0]  ONE_D    = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [FRAMES:0] ONE_L    = {{FRAMES{1'b0}}, 1'b1};

    // Command codes (6 and 7 fall through to the default and do nothing)
    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_PUSH  = 3'd1;
    localparam logic [2:0] CMD_POP   = 3'd2;
    localparam logic [2:0] CMD_CALL  = 3'd3;
    localparam logic [2:0] CMD_RET   = 3'd4;
    localparam logic [2:0] CMD_DROPN = 3'd5;

    // Stack op codes; code 3 (replace) exists on the stack side but this
    // controller never issues it
    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    // Error codes
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OVER  = 2'd1;
    localparam logic [1:0] ERR_UNDER = 2'd2;
`ifdef FRAME_CTRL_ARITY_CHECK_EN
    localparam logic [1:0] ERR_ARITY = 2'd3;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DROP = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state;
    logic [DEPTH:0]    drop_left;     // pops still owed by the current DROPN
    logic [DEPTH:0]    lifo [NFRAMES];

    // ------------------------------------------------------------------------
    // Command decode helpers
    // ------------------------------------------------------------------------
    logic              accept;
    logic [DEPTH:0]    avail;         // entries above the current limit
    logic              lifo_full;
    logic              call_ok;
    logic [FRAMES-1:0] top_idx;
    logic [DEPTH:0]    lifo_top;

    // Commands are taken only in IDLE; reset masks ready in the same cycle
    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // depth never drops below stk_limit, so this difference cannot wrap
    assign avail     = depth - stk_limit;
    assign lifo_full = (level == MAXF);

    // A CALL that actually saves a frame; shared by the FSM and the LIFO
    assign call_ok   = accept && (cmd == CMD_CALL) && !lifo_full
                       && (cmd_count <= avail);

    // Top-of-LIFO slot; the value read at level 0 is never used
    assign top_idx   = level[FRAMES-1:0] - FRAMES'(1);
    assign lifo_top  = lifo[top_idx];

    // ------------------------------------------------------------------------
    // Frame LIFO storage: saves the outgoing limit on every successful CALL.
    // Contents are don't-care after reset, so the array carries no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (call_ok) begin
            lifo[level[FRAMES-1:0]] <= stk_limit;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: decodes accepted commands, drives all registered outputs
    // and sequences multi-cycle DROPN pops.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            depth     <= '0;
            stk_limit <= '0;
            level     <= '0;
            err       <= ERR_NONE;
            busy      <= 1'b0;
            stk_op    <= OP_NONE;
            stk_data  <= '0;
            drop_left <= '0;
        end else begin
            // Stack ops are single-cycle pulses unless re-issued below
            stk_op <= OP_NONE;

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_NOP: begin
                            end

                            CMD_PUSH: begin
                                if (depth < MAXD) begin
                                    stk_op   <= OP_PUSH;
                                    stk_data <= cmd_data;
                                    depth    <= depth + ONE_D;
                                end else begin
                                    err <= ERR_OVER;
                                end
                            end

                            CMD_POP: begin
                                if (depth > stk_limit) begin
                                    stk_op <= OP_POP;
                                    depth  <= depth - ONE_D;
                                end else begin
                                    err <= ERR_UNDER;
                                end
                            end

                            CMD_CALL: begin
                                // Full LIFO takes precedence over short operands
                                if (lifo_full) begin
                                    err <= ERR_OVER;
                                end else if (cmd_count > avail) begin
                                    err <= ERR_UNDER;
                                end else begin
                                    // The callee's frame starts below its arguments
                                    stk_limit <= depth - cmd_count;
                                    level     <= level + ONE_L;
                                end
                            end

                            CMD_RET: begin
                                if (level == '0) begin
                                    err <= ERR_UNDER;
                                end
`ifdef FRAME_CTRL_ARITY_CHECK_EN
                                else if (cmd_count != avail) begin
                                    err <= ERR_ARITY;
                                end
`endif
                                else begin
                                    // Results stay on the stack; only the limit moves
                                    stk_limit <= lifo_top;
                                    level     <= level - ONE_L;
                                end
                            end

                            CMD_DROPN: begin
                                if (cmd_count == '0) begin
                                    // Nothing to drop
                                end else if (cmd_count > avail) begin
                                    err <= ERR_UNDER;
                                end else begin
                                    // First pop goes out with the accept so busy
                                    // lines up exactly with the pop pulses
                                    state     <= DROP;
                                    busy      <= 1'b1;
                                    stk_op    <= OP_POP;
                                    depth     <= depth - ONE_D;
                                    drop_left <= cmd_count - ONE_D;
                                end
                            end

                            default: begin
                            end
                        endcase
                    end
                end

                DROP: begin
                    if (drop_left == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        stk_op    <= OP_POP;
                        depth     <= depth - ONE_D;
                        drop_left <= drop_left - ONE_D;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_ctrl
//  Description : Self-checking bench for frame_ctrl (WIDTH=8, DEPTH=3,
//                FRAMES=2). A vector table covers the single-cycle commands;
//                hand-written sequences cover DROPN, reset during DROP and
//                the RET arity option (FRAME_CTRL_ARITY_CHECK_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_ctrl;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 3;
    localparam int FRAMES = 2;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2,
                           CALL = 3'd3, RET = 3'd4, DROPN = 3'd5;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd;
    logic [WIDTH-1:0] cmd_data;
    logic [DEPTH:0]   cmd_count;
    logic [1:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [DEPTH:0]   stk_limit;
    logic [DEPTH:0]   depth;
    logic [FRAMES:0]  level;
    logic             busy;
    logic [1:0]       err;

    int checks   = 0;
    int failures = 0;

    frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .stk_op    (stk_op),
        .stk_data  (stk_data),
        .stk_limit (stk_limit),
        .depth     (depth),
        .level     (level),
        .busy      (busy),
        .err       (err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       cmd;
        logic [WIDTH-1:0] data;
        logic [DEPTH:0]   count;
        logic [1:0]       op;
        logic [WIDTH-1:0] sdata;
        logic [DEPTH:0]   d;
        logic [DEPTH:0]   lim;
        logic [FRAMES:0]  lv;
        logic [1:0]       e;
    } vec_t;

    vec_t tbl [40];
    int   nvec = 0;

    task automatic add(input logic [2:0] c, input logic [7:0] dt, input logic [3:0] n,
                       input logic [1:0] op, input logic [7:0] sd, input logic [3:0] d,
                       input logic [3:0] lim, input logic [2:0] lv, input logic [1:0] e);
        tbl[nvec].cmd   = c;
        tbl[nvec].data  = dt;
        tbl[nvec].count = n;
        tbl[nvec].op    = op;
        tbl[nvec].sdata = sd;
        tbl[nvec].d     = d;
        tbl[nvec].lim   = lim;
        tbl[nvec].lv    = lv;
        tbl[nvec].e     = e;
        nvec++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", nm, idx, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] dt, input logic [3:0] n);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = dt;
        cmd_count = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset(input int tag);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = NOP;
        cmd_data  = '0;
        cmd_count = '0;
        tick();
        tick();
        chk("ready_in_reset", tag, 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    task automatic chk_state(input string nm, input int tag, input logic [1:0] op,
                             input logic [3:0] d, input logic [3:0] lim,
                             input logic [2:0] lv, input logic [1:0] e);
        chk({nm, "_op"},    tag, 32'(stk_op),    32'(op));
        chk({nm, "_depth"}, tag, 32'(depth),     32'(d));
        chk({nm, "_limit"}, tag, 32'(stk_limit), 32'(lim));
        chk({nm, "_level"}, tag, 32'(level),     32'(lv));
        chk({nm, "_err"},   tag, 32'(err),       32'(e));
    endtask

    initial begin
        // -------------------------------------------------------------
        // Vector table: one command per cycle, outputs checked after it
        //    cmd    data   cnt  op  sdata  d  lim lv err
        // -------------------------------------------------------------
        add(PUSH,  8'h11, 4'd0, 2'd1, 8'h11, 4'd1, 4'd0, 3'd0, 2'd0);
        add(PUSH,  8'h22, 4'd0, 2'd1, 8'h22, 4'd2, 4'd0, 3'd0, 2'd0);
        add(PUSH,  8'h33, 4'd0, 2'd1, 8'h33, 4'd3, 4'd0, 3'd0, 2'd0);
        add(CALL,  8'h00, 4'd2, 2'd0, 8'h00, 4'd3, 4'd1, 3'd1, 2'd0);
        add(POP,   8'h00, 4'd0, 2'd2, 8'h00, 4'd2, 4'd1, 3'd1, 2'd0);
        add(POP,   8'h00, 4'd0, 2'd2, 8'h00, 4'd1, 4'd1, 3'd1, 2'd0);
        add(POP,   8'h00, 4'd0, 2'd0, 8'h00, 4'd1, 4'd1, 3'd1, 2'd2); // at limit
        add(NOP,   8'hFF, 4'd3, 2'd0, 8'h00, 4'd1, 4'd1, 3'd1, 2'd2); // sticky
        add(3'd7,  8'hFF, 4'd1, 2'd0, 8'h00, 4'd1, 4'd1, 3'd1, 2'd2); // code 7
        add(RET,   8'h00, 4'd0, 2'd0, 8'h00, 4'd1, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h44, 4'd0, 2'd1, 8'h44, 4'd2, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h55, 4'd0, 2'd1, 8'h55, 4'd3, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h66, 4'd0, 2'd1, 8'h66, 4'd4, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h77, 4'd0, 2'd1, 8'h77, 4'd5, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h88, 4'd0, 2'd1, 8'h88, 4'd6, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'h99, 4'd0, 2'd1, 8'h99, 4'd7, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'hAA, 4'd0, 2'd1, 8'hAA, 4'd8, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'hBB, 4'd0, 2'd0, 8'h00, 4'd8, 4'd0, 3'd0, 2'd1); // stack full
        add(CALL,  8'h00, 4'd9, 2'd0, 8'h00, 4'd8, 4'd0, 3'd0, 2'd2); // too few
        add(CALL,  8'h00, 4'd8, 2'd0, 8'h00, 4'd8, 4'd0, 3'd1, 2'd2);
        add(CALL,  8'h00, 4'd6, 2'd0, 8'h00, 4'd8, 4'd2, 3'd2, 2'd2);
        add(CALL,  8'h00, 4'd4, 2'd0, 8'h00, 4'd8, 4'd4, 3'd3, 2'd2);
        add(CALL,  8'h00, 4'd2, 2'd0, 8'h00, 4'd8, 4'd6, 3'd4, 2'd2);
        add(CALL,  8'h00, 4'd0, 2'd0, 8'h00, 4'd8, 4'd6, 3'd4, 2'd1); // LIFO full
        add(DROPN, 8'h00, 4'd3, 2'd0, 8'h00, 4'd8, 4'd6, 3'd4, 2'd2); // too many
        add(DROPN, 8'h00, 4'd0, 2'd0, 8'h00, 4'd8, 4'd6, 3'd4, 2'd2); // count 0
        add(RET,   8'h00, 4'd2, 2'd0, 8'h00, 4'd8, 4'd4, 3'd3, 2'd2);
        add(RET,   8'h00, 4'd4, 2'd0, 8'h00, 4'd8, 4'd2, 3'd2, 2'd2);
        add(RET,   8'h00, 4'd6, 2'd0, 8'h00, 4'd8, 4'd0, 3'd1, 2'd2);
        add(RET,   8'h00, 4'd8, 2'd0, 8'h00, 4'd8, 4'd0, 3'd0, 2'd2);
        add(PUSH,  8'hCC, 4'd0, 2'd0, 8'h00, 4'd8, 4'd0, 3'd0, 2'd1); // still full
        add(RET,   8'h00, 4'd0, 2'd0, 8'h00, 4'd8, 4'd0, 3'd0, 2'd2); // level 0
        add(POP,   8'h00, 4'd0, 2'd2, 8'h00, 4'd7, 4'd0, 3'd0, 2'd2);

        // -------------------------------------------------------------
        // Reset values, then the table starting on the first free cycle
        // -------------------------------------------------------------
        do_reset(0);
        chk("rst_ready", 0, 32'(cmd_ready), 32'd1);
        chk("rst_busy",  0, 32'(busy),      32'd0);
        chk("rst_data",  0, 32'(stk_data),  32'd0);
        chk_state("rst", 0, 2'd0, 4'd0, 4'd0, 3'd0, 2'd0);

        for (int i = 0; i < nvec; i++) begin
            issue(tbl[i].cmd, tbl[i].data, tbl[i].count);
            chk_state("vec", i, tbl[i].op, tbl[i].d, tbl[i].lim, tbl[i].lv, tbl[i].e);
            chk("vec_ready", i, 32'(cmd_ready), 32'd1);
            if (tbl[i].op == 2'd1) begin
                chk("vec_data", i, 32'(stk_data), 32'(tbl[i].sdata));
            end
        end

        // -------------------------------------------------------------
        // DROPN 3 from depth 5; a PUSH held valid during the drop must
        // wait until the controller returns to IDLE
        // -------------------------------------------------------------
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            issue(PUSH, 8'(i), 4'd0);
        end
        chk("pre_drop_depth", 1, 32'(depth), 32'd5);
        issue(DROPN, 8'h00, 4'd3);
        cmd_valid = 1'b1;
        cmd       = PUSH;
        cmd_data  = 8'h5A;
        cmd_count = '0;
        for (int i = 0; i < 3; i++) begin
            chk("drop_busy",  i, 32'(busy),      32'd1);
            chk("drop_op",    i, 32'(stk_op),    32'd2);
            chk("drop_depth", i, 32'(depth),     32'(4 - i));
            chk("drop_ready", i, 32'(cmd_ready), 32'd0);
            tick();
        end
        chk("drop_end_busy",  0, 32'(busy),      32'd0);
        chk("drop_end_op",    0, 32'(stk_op),    32'd0);
        chk("drop_end_depth", 0, 32'(depth),     32'd2);
        chk("drop_end_ready", 0, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("post_drop_op",    0, 32'(stk_op),   32'd1);
        chk("post_drop_data",  0, 32'(stk_data), 32'h5A);
        chk("post_drop_depth", 0, 32'(depth),    32'd3);
        tick();
        chk("post_drop_idle",  0, 32'(stk_op),   32'd0);

        // -------------------------------------------------------------
        // Reset in the second cycle of DROPN 4 aborts the drop
        // -------------------------------------------------------------
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            issue(PUSH, 8'hA0, 4'd0);
        end
        issue(DROPN, 8'h00, 4'd4);
        chk("abort_c1_op",   0, 32'(stk_op), 32'd2);
        chk("abort_c1_busy", 0, 32'(busy),   32'd1);
        tick();
        chk("abort_c2_depth", 0, 32'(depth), 32'd2);
        reset = 1'b1;
        #1;
        chk("abort_ready_rst", 0, 32'(cmd_ready), 32'd0);
        tick();
        chk("abort_op",    0, 32'(stk_op), 32'd0);
        chk("abort_depth", 0, 32'(depth),  32'd0);
        chk("abort_busy",  0, 32'(busy),   32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", 0, 32'(cmd_ready), 32'd1);
        tick();
        chk("abort_after_op",   0, 32'(stk_op), 32'd0);
        chk("abort_after_busy", 0, 32'(busy),   32'd0);

        // -------------------------------------------------------------
        // RET result count: limit 1, depth 3
        // -------------------------------------------------------------
        do_reset(3);
        issue(PUSH, 8'h01, 4'd0);
        issue(PUSH, 8'h02, 4'd0);
        issue(PUSH, 8'h03, 4'd0);
        issue(CALL, 8'h00, 4'd2);
        chk_state("arity_setup", 0, 2'd0, 4'd3, 4'd1, 3'd1, 2'd0);
        issue(RET, 8'h00, 4'd1);
`ifdef FRAME_CTRL_ARITY_CHECK_EN
        chk_state("arity_bad", 0, 2'd0, 4'd3, 4'd1, 3'd1, 2'd3);
        issue(RET, 8'h00, 4'd2);
        chk_state("arity_good", 0, 2'd0, 4'd3, 4'd0, 3'd0, 2'd3);
`else
        chk_state("arity_off", 0, 2'd0, 4'd3, 4'd0, 3'd0, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_ctrl.md
FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: stack data width in bits.
REQ-002 Parameter DEPTH, default 8: stack index width is DEPTH+1 bits; stack capacity is MAXD = 2^DEPTH entries.
REQ-003 Parameter FRAMES, default 4: the frame LIFO holds 2^FRAMES saved limits.
REQ-004 clk  in  1: clock, all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 cmd_valid  in  1: a command is presented.
REQ-007 cmd_ready  out  1: the controller accepts a command this cycle.
REQ-008 cmd  in  3: command code; 0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 DROPN; codes 6-7 are treated as NOP.
REQ-009 cmd_data  in  WIDTH: value for PUSH.
REQ-010 cmd_count  in  DEPTH+1: argument count for CALL, result count for RET, and drop count for DROPN.
REQ-011 stk_op  out  2: registered op to the stack; 0 none, 1 push, 2 pop, 3 replace.
REQ-012 stk_data  out  WIDTH: registered push data.
REQ-013 stk_limit  out  DEPTH+1: registered underflow limit driven to the stack.
REQ-014 depth  out  DEPTH+1: controller's tracked stack index.
REQ-015 level  out  FRAMES+1: number of saved frames.
REQ-016 busy  out  1: a multi-cycle DROPN is in progress.
REQ-017 err  out  2: sticky error; 0 none, 1 frame overflow, 2 underflow, 3 arity mismatch.

Function
REQ-018 States SHALL be IDLE and DROP; cmd_ready SHALL equal (state==IDLE && !reset).
REQ-019 Accept SHALL mean cmd_valid && cmd_ready; stk_op SHALL be 0 in any cycle following a non-op cycle.
REQ-020 PUSH SHALL behave as follows. If depth < MAXD: stk_op=1 and stk_data=cmd_data for one cycle, and depth+1. If depth == MAXD: no stack op, err=2 is not used, and err SHALL be set to 1.
REQ-021 POP SHALL behave as follows. If depth > stk_limit: stk_op=2 for one cycle and depth-1. Otherwise: no op and err=2.
REQ-022 CALL SHALL behave as follows. If level < 2^FRAMES and cmd_count <= depth-stk_limit: push the current stk_limit onto the frame LIFO, set stk_limit = depth-cmd_count, and increment level. If the LIFO is full: err=1 and no change. If there are too few operands: err=2 and no change.
REQ-023 RET SHALL behave as follows. If level == 0: err=2 and no change. Otherwise: pop the LIFO into stk_limit and decrement level. depth SHALL be unchanged.
REQ-024 DROPN with cmd_count=0 SHALL be a NOP.
REQ-025 DROPN with cmd_count > depth-stk_limit SHALL set err=2 and issue no ops.
REQ-026 DROPN in all other cases SHALL enter DROP and issue stk_op=2 on cmd_count consecutive cycles, decrementing depth each cycle, then return to IDLE; busy SHALL be 1 exactly while in DROP.
REQ-027 All outputs SHALL be registered; a stack op SHALL appear on stk_op the cycle after acceptance.
REQ-028 err SHALL hold its value until reset; a later error SHALL overwrite it with the newer code.
REQ-029 NOP and codes 6-7 SHALL change nothing.
REQ-030 Arithmetic SHALL be unsigned at DEPTH+1 bits; the guards above SHALL prevent depth and stk_limit from wrapping.

Reset
REQ-031 On reset: state=IDLE, depth=0, stk_limit=0, level=0, err=0, busy=0, stk_op=0, stk_data=0; the frame LIFO contents are don't-care.
REQ-032 Reset asserted during DROP SHALL abort the DROP immediately; stk_op SHALL be 0 on the next cycle.
REQ-033 The first command SHALL be accepted in the cycle after reset deasserts.

Configuration
REQ-034 The macro FRAME_CTRL_ARITY_CHECK_EN SHALL control result-count checking on RET.
REQ-035 With FRAME_CTRL_ARITY_CHECK_EN defined, RET with level > 0 and (depth - stk_limit) != cmd_count SHALL set err=3 and leave stk_limit and level unchanged.
REQ-036 Without FRAME_CTRL_ARITY_CHECK_EN, cmd_count SHALL be ignored on RET and no arity check SHALL be made.

Verification
REQ-037 Scenario: after reset, PUSH 0x11, 0x22, 0x33 -> stk_op=1 on three consecutive cycles with matching stk_data, depth=3, err=0.
REQ-038 Scenario: depth=3, CALL count=2 -> stk_limit=1, level=1; then POP x2 -> depth=1; then a third POP -> no stk_op and err=2.
REQ-039 Scenario: depth=5, limit=0, DROPN count=3 -> busy=1 for 3 cycles, three stk_op=2 pulses, depth=2, cmd_ready low throughout.
REQ-040 Scenario: FRAMES=2, issue 5 CALLs with count 0 -> the first 4 succeed with level=4, and the 5th sets err=1 with level still 4.
REQ-041 Scenario (macro on): limit=1, depth=3, RET count=1 -> err=3 and limit stays 1; RET count=2 -> limit restored to 0, level-1.
REQ-042 Scenario: reset asserted on the 2nd cycle of DROPN count=4 -> stk_op=0 next cycle, depth=0, busy=0, cmd_ready=1 after release.
